// File: rtl/pipe_stall_ctrl.sv
// pipe_stall_ctrl: stall controller for the five-stage core.
// Merges ID/EX stall requests and flush into the stall_en vector. It also
// contains the multi-cycle EX countdown sequencer and a saturating count of
// stalled cycles.
module pipe_stall_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             id_stall_req,
    input  logic             ex_stall_req,
    input  logic             mc_start,
    input  logic [5:0]       mc_cycles,
    input  logic             flush,
    output logic [5:0]       stall_en,
    output logic             mc_busy,
    output logic             mc_done,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Only three stall patterns are ever emitted. Each downstream register
    // bubbles where its own bit is 1 and the next bit is 0.
    localparam logic [5:0] SE_NONE = 6'b000000;
    localparam logic [5:0] SE_ID   = 6'b000111;
    localparam logic [5:0] SE_EX   = 6'b001111;

    logic [1:0]       state_r;
    logic [1:0]       state_nxt_s;
    logic [5:0]       mc_cnt_r;
    logic [5:0]       mc_cnt_nxt_s;
    logic             can_start_s;
    logic             seq_hold_s;
    logic [5:0]       stall_en_s;
    logic             mc_busy_r;
    logic             mc_done_r;
    logic [CNT_W-1:0] stall_cnt_r;

    // Decide whether the sequencer holds EX this cycle. A new start holds EX
    // in its own cycle, before the FSM has left IDLE or DONE.
    always_comb begin
        can_start_s = (state_r == ST_IDLE) || (state_r == ST_DONE);
        seq_hold_s  = (state_r == ST_BUSY) ||
                      (can_start_s && mc_start && (mc_cycles != 6'd0));
    end

    // Priority merge of the stall sources: flush, then EX hold, then ID hazard.
    always_comb begin
        stall_en_s = SE_NONE;
        if (flush) begin
            stall_en_s = SE_NONE;
        end else if (ex_stall_req || seq_hold_s) begin
            stall_en_s = SE_EX;
        end else if (id_stall_req) begin
            stall_en_s = SE_ID;
        end else begin
            stall_en_s = SE_NONE;
        end
    end

    // Next-state logic for the countdown sequencer. BUSY exits at a count of
    // 1, so the 6-bit counter never wraps.
    always_comb begin
        state_nxt_s  = state_r;
        mc_cnt_nxt_s = mc_cnt_r;
        if (flush) begin
            state_nxt_s  = ST_IDLE;
            mc_cnt_nxt_s = 6'd0;
        end else begin
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    if (mc_start && (mc_cycles >= 6'd2)) begin
                        state_nxt_s  = ST_BUSY;
                        mc_cnt_nxt_s = mc_cycles - 6'd1;
                    end else if (mc_start && (mc_cycles == 6'd1)) begin
                        state_nxt_s  = ST_DONE;
                        mc_cnt_nxt_s = 6'd0;
                    end else begin
                        state_nxt_s  = ST_IDLE;
                        mc_cnt_nxt_s = 6'd0;
                    end
                end
                ST_BUSY: begin
                    if (mc_cnt_r > 6'd1) begin
                        state_nxt_s  = ST_BUSY;
                        mc_cnt_nxt_s = mc_cnt_r - 6'd1;
                    end else begin
                        state_nxt_s  = ST_DONE;
                        mc_cnt_nxt_s = 6'd0;
                    end
                end
                default: begin
                    state_nxt_s  = ST_IDLE;
                    mc_cnt_nxt_s = 6'd0;
                end
            endcase
        end
    end

    // Sequencer state and countdown registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r  <= ST_IDLE;
            mc_cnt_r <= 6'd0;
        end else begin
            state_r  <= state_nxt_s;
            mc_cnt_r <= mc_cnt_nxt_s;
        end
    end

    // Registered status flags, decoded from the next state so they track
    // state_r exactly.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mc_busy_r <= 1'b0;
            mc_done_r <= 1'b0;
        end else begin
            mc_busy_r <= (state_nxt_s == ST_BUSY);
            mc_done_r <= (state_nxt_s == ST_DONE);
        end
    end

    // Saturating count of cycles in which the PC was held. Flush does not
    // clear it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt_r <= {CNT_W{1'b0}};
        end else if (stall_en_s[0] && (stall_cnt_r != {CNT_W{1'b1}})) begin
            stall_cnt_r <= stall_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

    assign stall_en  = stall_en_s;
    assign mc_busy   = mc_busy_r;
    assign mc_done   = mc_done_r;
    assign stall_cnt = stall_cnt_r;

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Self-checking bench for pipe_stall_ctrl. A behavioural reference model
// pushes the expected outputs of every cycle into a scoreboard queue.
// Entries are popped and compared when the DUT outputs are sampled on the
// falling edge.
module tb_pipe_stall_ctrl;

    localparam int CW = 4;

    logic          clk;
    logic          reset;
    logic          id_stall_req;
    logic          ex_stall_req;
    logic          mc_start;
    logic [5:0]    mc_cycles;
    logic          flush;
    logic [5:0]    stall_en;
    logic          mc_busy;
    logic          mc_done;
    logic [CW-1:0] stall_cnt;

    typedef struct {
        logic [5:0]    se;
        logic          busy;
        logic          done;
        logic [CW-1:0] cnt;
    } exp_t;

    exp_t sb_q[$];

    int tests_run;
    int tests_failed;

    // Reference model state: 0 idle, 1 busy, 2 done.
    int         m_state;
    int         m_rem;
    logic [CW-1:0] m_scnt;

    pipe_stall_ctrl #(.CNT_W(CW)) dut (
        .clk          (clk),
        .reset        (reset),
        .id_stall_req (id_stall_req),
        .ex_stall_req (ex_stall_req),
        .mc_start     (mc_start),
        .mc_cycles    (mc_cycles),
        .flush        (flush),
        .stall_en     (stall_en),
        .mc_busy      (mc_busy),
        .mc_done      (mc_done),
        .stall_cnt    (stall_cnt)
    );

    // 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Drive one cycle of stimulus, then score it against the model and
    // advance the model. The task is entered and left at posedge+1.
    task automatic cyc(input logic id, input logic ex, input logic st,
                       input logic [5:0] n, input logic fl);
        exp_t e;
        exp_t got;
        bit   hold;
        id_stall_req = id;
        ex_stall_req = ex;
        mc_start     = st;
        mc_cycles    = n;
        flush        = fl;
        hold = (m_state == 1) || ((m_state != 1) && st && (n != 6'd0));
        if (fl)             e.se = 6'b000000;
        else if (ex || hold) e.se = 6'b001111;
        else if (id)        e.se = 6'b000111;
        else                e.se = 6'b000000;
        e.busy = (m_state == 1);
        e.done = (m_state == 2);
        e.cnt  = m_scnt;
        sb_q.push_back(e);
        #4;
        got = sb_q.pop_front();
        check_val("stall_en",  {26'd0, stall_en},  {26'd0, got.se});
        check_val("mc_busy",   {31'd0, mc_busy},   {31'd0, got.busy});
        check_val("mc_done",   {31'd0, mc_done},   {31'd0, got.done});
        check_val("stall_cnt", {28'd0, stall_cnt}, {28'd0, got.cnt});
        // advance the model to the next cycle
        if (e.se[0] && (m_scnt != 4'hF)) m_scnt = m_scnt + 4'd1;
        if (fl) begin
            m_state = 0;
            m_rem   = 0;
        end else if (m_state == 1) begin
            if (m_rem > 1) m_rem = m_rem - 1;
            else begin m_state = 2; m_rem = 0; end
        end else begin
            if (st && n >= 6'd2) begin m_state = 1; m_rem = int'(n) - 1; end
            else if (st && n == 6'd1) m_state = 2;
            else m_state = 0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) cyc(1'b0, 1'b0, 1'b0, 6'd0, 1'b0);
    endtask

    initial begin
        logic [CW-1:0] snap;
        tests_run    = 0;
        tests_failed = 0;
        m_state = 0; m_rem = 0; m_scnt = '0;
        reset = 1'b0;
        id_stall_req = 1'b0; ex_stall_req = 1'b0; mc_start = 1'b0;
        mc_cycles = 6'd0; flush = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;

        // reset state
        idle(2);

        // single ID hazard cycle, then the count shows it
        cyc(1'b1, 1'b0, 1'b0, 6'd0, 1'b0);
        idle(1);
        check_val("cnt_after_id", {28'd0, stall_cnt}, 32'd1);

        // N=3 multi-cycle op
        snap = stall_cnt;
        cyc(1'b0, 1'b0, 1'b1, 6'd3, 1'b0);
        idle(3);
        check_val("cnt_delta_n3", {28'd0, stall_cnt - snap}, 32'd3);
        idle(1);

        // N=1 and N=0
        cyc(1'b0, 1'b0, 1'b1, 6'd1, 1'b0);
        idle(2);
        cyc(1'b0, 1'b0, 1'b1, 6'd0, 1'b0);
        idle(2);

        // ID and EX requests together
        cyc(1'b1, 1'b1, 1'b0, 6'd0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 6'd0, 1'b0);
        idle(1);

        // N=5 with a second start (N=2) while busy: ignored
        cyc(1'b0, 1'b0, 1'b1, 6'd5, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 6'd2, 1'b0);
        idle(5);

        // N=4 with flush in second BUSY cycle, ID request high
        cyc(1'b0, 1'b0, 1'b1, 6'd4, 1'b0);
        idle(1);
        cyc(1'b1, 1'b0, 1'b0, 6'd0, 1'b1);
        idle(4);

        // back-to-back: new start in the DONE cycle, flush while DONE
        cyc(1'b0, 1'b0, 1'b1, 6'd2, 1'b0);
        idle(1);
        cyc(1'b0, 1'b0, 1'b1, 6'd3, 1'b0);
        idle(2);
        cyc(1'b0, 1'b1, 1'b0, 6'd0, 1'b1);
        idle(2);

        // flush discards a start in the same cycle
        cyc(1'b0, 1'b0, 1'b1, 6'd3, 1'b1);
        idle(2);

        // saturation of the stall counter
        for (int i = 0; i < 18; i++) cyc(1'b1, 1'b0, 1'b0, 6'd0, 1'b0);
        idle(1);
        check_val("cnt_saturated", {28'd0, stall_cnt}, 32'd15);

        // asynchronous reset mid-BUSY
        cyc(1'b0, 1'b0, 1'b1, 6'd6, 1'b0);
        idle(1);
        #2 reset = 1'b0;
        #1;
        check_val("rst_busy", {31'd0, mc_busy}, 32'd0);
        check_val("rst_done", {31'd0, mc_done}, 32'd0);
        check_val("rst_cnt",  {28'd0, stall_cnt}, 32'd0);
        check_val("rst_se",   {26'd0, stall_en}, 32'd0);
        m_state = 0; m_rem = 0; m_scnt = '0;
        @(posedge clk);
        #1 reset = 1'b1;
        idle(1);
        cyc(1'b1, 1'b0, 1'b0, 6'd0, 1'b0);
        idle(1);
        check_val("cnt_after_rst", {28'd0, stall_cnt}, 32'd1);

        check_val("sb_empty", sb_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
